// File: rtl/branch_resolve.sv
// branch_resolve - in-flight branch prediction queue, resolution, flush/redirect and predictor update
module branch_resolve #(
    parameter int DEPTH     = 4,
    parameter int FLUSH_CYC = 2,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pred_valid,
    input  logic             pred_taken,
    input  logic [31:0]      pred_pc,
    input  logic [31:0]      pred_target,
    input  logic             res_valid,
    input  logic             res_taken,
    input  logic [31:0]      res_pc,
    input  logic [31:0]      res_target,
    output logic             stall_id,
    output logic             flush,
    output logic [31:0]      redirect_pc,
    output logic             upd_valid,
    output logic [31:0]      upd_pc,
    output logic             upd_taken,
    output logic [31:0]      upd_target,
    output logic             tag_err,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] mp_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int RW = $clog2(FLUSH_CYC + 1);
    localparam logic [AW:0]   FULL   = (AW + 1)'(DEPTH);
    localparam logic [RW-1:0] RELOAD = RW'(FLUSH_CYC);

    typedef enum logic {IDLE, RECOVER} state_t;
    state_t state, state_nx;

    logic          q_taken [DEPTH];
    logic [31:0]   q_pc    [DEPTH];
    logic [31:0]   q_target[DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [RW-1:0] rcnt;

    logic        empty, resolve, mispredict, bad_tag, push, pop;
    logic        head_taken;
    logic [31:0] head_pc, head_target;

    // An empty queue resolves against a synthetic not-taken head.
    always_comb begin
        empty       = (count == '0);
        head_taken  = empty ? 1'b0  : q_taken[rd_ptr];
        head_pc     = empty ? '0    : q_pc[rd_ptr];
        head_target = empty ? '0    : q_target[rd_ptr];
        resolve     = res_valid & (state == IDLE);
        mispredict  = resolve & ((head_taken != res_taken) |
                                 (res_taken & (head_target != res_target)));
        bad_tag     = resolve & (empty | (head_pc != res_pc));
        stall_id    = ((count == FULL) & ~res_valid) | (state == RECOVER);
        push        = pred_valid & ~stall_id & ~mispredict;
        pop         = resolve & ~empty;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (mispredict) state_nx = RECOVER;
            RECOVER: if (rcnt <= RW'(1)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rcnt  <= '0;
        end else begin
            state <= state_nx;
            if (mispredict)
                rcnt <= RELOAD;
            else if (state == RECOVER && rcnt != '0)
                rcnt <= rcnt - RW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_taken[wr_ptr]  <= pred_taken;
            q_pc[wr_ptr]     <= pred_pc;
            q_target[wr_ptr] <= pred_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            flush       <= 1'b0;
            redirect_pc <= '0;
            upd_valid   <= 1'b0;
            upd_pc      <= '0;
            upd_taken   <= 1'b0;
            upd_target  <= '0;
            tag_err     <= 1'b0;
            br_cnt      <= '0;
            mp_cnt      <= '0;
        end else begin
            flush     <= mispredict;
            upd_valid <= resolve;
            tag_err   <= tag_err | bad_tag;
            if (mispredict) begin
                // Everything younger than a mispredicted branch is wrong-path.
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                if (push && !pop)      count <= count + (AW + 1)'(1);
                else if (!push && pop) count <= count - (AW + 1)'(1);
            end
            if (resolve) begin
                upd_pc     <= res_pc;
                upd_taken  <= res_taken;
                upd_target <= res_target;
                if (br_cnt != '1) br_cnt <= br_cnt + CNT_W'(1);
            end
            if (mispredict) begin
                redirect_pc <= res_taken ? res_target : res_pc;
                if (mp_cnt != '1) mp_cnt <= mp_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - scoreboard bench for branch_resolve
module tb_branch_resolve;
    localparam int DEPTH = 4;
    localparam int FLUSH = 2;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 0;
    logic          rst_n = 0;
    logic          pred_valid = 0, pred_taken = 0;
    logic [31:0]   pred_pc = 0, pred_target = 0;
    logic          res_valid = 0, res_taken = 0;
    logic [31:0]   res_pc = 0, res_target = 0;
    logic          stall_id, flush, upd_valid, upd_taken, tag_err;
    logic [31:0]   redirect_pc, upd_pc, upd_target;
    logic [CW-1:0] br_cnt, mp_cnt;

    branch_resolve #(.DEPTH(DEPTH), .FLUSH_CYC(FLUSH), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .pred_valid(pred_valid), .pred_taken(pred_taken),
        .pred_pc(pred_pc), .pred_target(pred_target),
        .res_valid(res_valid), .res_taken(res_taken),
        .res_pc(res_pc), .res_target(res_target),
        .stall_id(stall_id), .flush(flush), .redirect_pc(redirect_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .tag_err(tag_err),
        .br_cnt(br_cnt), .mp_cnt(mp_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        t;
        logic [31:0] pc;
        logic [31:0] tg;
    } ent_t;

    typedef struct {
        logic [31:0] pc;
        logic        t;
        logic [31:0] tg;
        logic        mis;
        logic [31:0] rd;
    } exp_t;

    ent_t mq[$];
    exp_t sb[$];
    int   m_rec, m_br, m_mp;
    logic m_tag;
    int   checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        sb.delete();
        m_rec = 0;
        m_br  = 0;
        m_mp  = 0;
        m_tag = 0;
    endtask

    task automatic reset_chk();
        chk("rst_stall", 64'(stall_id), 0);
        chk("rst_flush", 64'(flush), 0);
        chk("rst_redirect", 64'(redirect_pc), 0);
        chk("rst_upd_valid", 64'(upd_valid), 0);
        chk("rst_upd_pc", 64'(upd_pc), 0);
        chk("rst_tag_err", 64'(tag_err), 0);
        chk("rst_br_cnt", 64'(br_cnt), 0);
        chk("rst_mp_cnt", 64'(mp_cnt), 0);
    endtask

    task automatic step(input logic pv, input logic pt, input logic [31:0] ppc, input logic [31:0] ptg,
                        input logic rv, input logic rt, input logic [31:0] rpc, input logic [31:0] rtg);
        ent_t h;
        exp_t e;
        logic mis, stall;
        pred_valid = pv; pred_taken = pt; pred_pc = ppc; pred_target = ptg;
        res_valid = rv; res_taken = rt; res_pc = rpc; res_target = rtg;
        #1;
        stall = ((mq.size() == DEPTH) && !rv) || (m_rec > 0);
        chk("stall_id", 64'(stall_id), 64'(stall));
        mis = 0;
        if (rv && m_rec == 0) begin
            if (mq.size() == 0) begin
                h.t = 0; h.pc = 0; h.tg = 0;
                m_tag = 1;
            end else begin
                h = mq.pop_front();
                if (h.pc != rpc) m_tag = 1;
            end
            mis = (h.t != rt) || (rt && h.tg != rtg);
            e.pc = rpc; e.t = rt; e.tg = rtg; e.mis = mis;
            e.rd = rt ? rtg : rpc;
            sb.push_back(e);
            if (m_br != CMAX) m_br++;
            if (mis && m_mp != CMAX) m_mp++;
            if (mis) mq.delete();
        end
        if (pv && !stall && !mis) mq.push_back('{pt, ppc, ptg});
        if (m_rec > 0) m_rec--;
        if (mis) m_rec = FLUSH;
        @(posedge clk);
        #1;
        pred_valid = 0;
        res_valid  = 0;
        chk("flush", 64'(flush), 64'(mis));
        chk("upd_valid", 64'(upd_valid), 64'(sb.size() != 0));
        if (upd_valid && sb.size() != 0) begin
            e = sb.pop_front();
            chk("upd_pc", 64'(upd_pc), 64'(e.pc));
            chk("upd_taken", 64'(upd_taken), 64'(e.t));
            chk("upd_target", 64'(upd_target), 64'(e.tg));
            if (e.mis) chk("redirect_pc", 64'(redirect_pc), 64'(e.rd));
        end
        chk("br_cnt", 64'(br_cnt), 64'(m_br));
        chk("mp_cnt", 64'(mp_cnt), 64'(m_mp));
        chk("tag_err", 64'(tag_err), 64'(m_tag));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic push(input logic t, input logic [31:0] pc, input logic [31:0] tg);
        step(1, t, pc, tg, 0, 0, 0, 0);
    endtask

    task automatic resolve(input logic t, input logic [31:0] pc, input logic [31:0] tg);
        step(0, 0, 0, 0, 1, t, pc, tg);
    endtask

    initial begin
        ent_t h;
        model_reset();
        #1;
        reset_chk();
        @(posedge clk);
        #1;
        rst_n = 1;

        // correct not-taken prediction
        push(0, 32'h104, 32'h0);
        resolve(0, 32'h104, 32'h0);

        // wrong direction with a younger entry behind it
        push(0, 32'h204, 32'h0);
        push(0, 32'h20C, 32'h0);
        resolve(1, 32'h204, 32'h300);
        step(1, 0, 32'h999, 0, 1, 1, 32'h20C, 32'h777);
        idle(1);
        push(0, 32'h50, 32'h0);
        resolve(0, 32'h50, 32'h0);

        // wrong target, then taken predicted but not taken
        push(1, 32'h404, 32'h400);
        resolve(1, 32'h404, 32'h480);
        idle(2);
        push(1, 32'h504, 32'h600);
        resolve(0, 32'h504, 32'h0);
        idle(2);

        // fill, stall, push+resolve at full, then wrap the pointers
        for (int i = 0; i < DEPTH; i++) push(i[0], 32'h1000 + 32'(i * 8), 32'h2000 + 32'(i * 16));
        push(0, 32'h1100, 0);
        for (int i = 0; i < 10; i++) begin
            h = mq[0];
            step(1, i[1], 32'h3000 + 32'(i * 8), 32'h4000 + 32'(i * 4), 1, h.t, h.pc, h.tg);
        end
        for (int i = 0; i < DEPTH; i++) begin
            h = mq[0];
            resolve(h.t, h.pc, h.tg);
        end
        idle(1);

        // resolve on empty queue, then tag mismatch
        resolve(1, 32'h604, 32'h680);
        idle(2);
        push(0, 32'h700, 0);
        resolve(0, 32'h708, 0);

        // mispredict counter saturation
        for (int i = 0; i < CMAX + 2; i++) begin
            resolve(1, 32'h900, 32'h800 + 32'(i * 4));
            idle(2);
        end

        // reset in the middle of a flush pulse
        push(0, 32'hA04, 0);
        push(0, 32'hA0C, 0);
        resolve(1, 32'hA04, 32'hB00);
        rst_n = 0;
        #1;
        model_reset();
        reset_chk();
        @(posedge clk);
        #1;
        rst_n = 1;
        push(0, 32'hC04, 0);
        resolve(0, 32'hC04, 0);
        idle(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
